// File: rtl/ipsxe_floating_point_comp_stream_v2_0.sv
// Streaming IEEE-754 comparator: joins A/B/op AXI-Stream beats, evaluates the
// requested predicate and carries the result through an elastic pipeline.
module ipsxe_floating_point_comp_stream_v2_0 #(
  parameter int unsigned EXPONENT_LENTH = 8,
  parameter int unsigned MANTISSA_LENTH = 23,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned HAS_OP_CHANNEL = 1,
  parameter logic [2:0]  FIXED_OP       = 3'b111,
  parameter int unsigned FLUSH_DENORM   = 0
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_aclken,
  input  logic                                     i_axis_a_tvalid,
  output logic                                     o_axis_a_tready,
  input  logic [EXPONENT_LENTH+MANTISSA_LENTH:0]   i_axis_a_tdata,
  input  logic                                     i_axis_a_tlast,
  input  logic                                     i_axis_b_tvalid,
  output logic                                     o_axis_b_tready,
  input  logic [EXPONENT_LENTH+MANTISSA_LENTH:0]   i_axis_b_tdata,
  input  logic                                     i_axis_operation_tvalid,
  output logic                                     o_axis_operation_tready,
  input  logic [2:0]                               i_axis_operation_tdata,
  output logic                                     o_axis_result_tvalid,
  input  logic                                     i_axis_result_tready,
  output logic [7:0]                               o_axis_result_tdata,
  output logic                                     o_axis_result_tuser,
  output logic                                     o_axis_result_tlast
);

  localparam int unsigned EW = EXPONENT_LENTH;
  localparam int unsigned MW = MANTISSA_LENTH;
  localparam int unsigned DW = 1 + EW + MW;
  localparam int unsigned PW = 6;  // {tlast, invalid, result[3:0]}
  localparam logic HAS_OP = (HAS_OP_CHANNEL != 0);
  localparam logic FLUSH  = (FLUSH_DENORM != 0);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]      pay_q [LATENCY];
  logic [PW-1:0]      pay_d [LATENCY];
  logic [LATENCY-1:0] free;

  logic          a_sign, b_sign;
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_mant, b_mant;
  logic          a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
  logic [DW-2:0] a_mag, b_mag;
  logic          unord, eq, lt_raw, lt, gt;
  logic [2:0]    op_sel;
  logic [3:0]    res_c;
  logic          inv_c;
  logic          all_valid, accept;

  assign a_sign = i_axis_a_tdata[DW-1];
  assign b_sign = i_axis_b_tdata[DW-1];
  assign a_exp  = i_axis_a_tdata[DW-2 -: EW];
  assign b_exp  = i_axis_b_tdata[DW-2 -: EW];
  assign a_mant = i_axis_a_tdata[MW-1:0];
  assign b_mant = i_axis_b_tdata[MW-1:0];

  // Operand classification and predicate evaluation for the beat being accepted
  always_comb begin
    a_nan  = (&a_exp) & (|a_mant);
    b_nan  = (&b_exp) & (|b_mant);
    a_snan = a_nan & ~a_mant[MW-1];
    b_snan = b_nan & ~b_mant[MW-1];
    a_zero = (a_exp == '0) & (~(|a_mant) | FLUSH);
    b_zero = (b_exp == '0) & (~(|b_mant) | FLUSH);
    // A flushed denormal must compare as a true zero magnitude
    a_mag  = a_zero ? '0 : {a_exp, a_mant};
    b_mag  = b_zero ? '0 : {b_exp, b_mant};
    unord  = a_nan | b_nan;
    eq     = ~unord & ((a_zero & b_zero) | (i_axis_a_tdata == i_axis_b_tdata));
    if (a_sign != b_sign) lt_raw = a_sign;
    else if (a_sign)      lt_raw = (a_mag > b_mag);
    else                  lt_raw = (a_mag < b_mag);
    lt     = ~unord & ~eq & lt_raw;
    gt     = ~unord & ~eq & ~lt_raw;
    op_sel = HAS_OP ? i_axis_operation_tdata : FIXED_OP;
    res_c  = 4'b0000;
    case (op_sel)
      3'b000:  res_c = {3'b000, unord};
      3'b001:  res_c = {3'b000, lt};
      3'b010:  res_c = {3'b000, eq};
      3'b011:  res_c = {3'b000, lt | eq};
      3'b100:  res_c = {3'b000, gt};
      3'b101:  res_c = {3'b000, ~eq};
      3'b110:  res_c = {3'b000, gt | eq};
      default: res_c = {unord, gt, lt, eq};
    endcase
    // Signalling NaNs always raise invalid; quiet NaNs only for ordered relations
    inv_c = a_snan | b_snan |
            (unord & ((op_sel == 3'b001) | (op_sel == 3'b011) |
                      (op_sel == 3'b100) | (op_sel == 3'b110)));
  end

  // Stage-free chain: a stage can load if it or any stage downstream can move
  always_comb begin
    logic f;
    f = ~vld_q[LATENCY-1] | i_axis_result_tready;
    free = '0;
    free[LATENCY-1] = f;
    for (int k = int'(LATENCY) - 2; k >= 0; k--) begin
      f = ~vld_q[k] | f;
      free[k] = f;
    end
  end

  assign all_valid = i_axis_a_tvalid & i_axis_b_tvalid & (i_axis_operation_tvalid | ~HAS_OP);
  assign accept    = all_valid & free[0] & i_aclken & ~i_rst;

  assign o_axis_a_tready         = accept;
  assign o_axis_b_tready         = accept;
  assign o_axis_operation_tready = HAS_OP ? accept : 1'b0;

  // Next-state of the elastic pipeline; everything holds while the clock enable is low
  always_comb begin
    vld_d = vld_q;
    pay_d = pay_q;
    if (i_aclken && free[0]) begin
      vld_d[0] = accept;
      pay_d[0] = {i_axis_a_tlast, inv_c, res_c};
    end
    for (int k = 1; k < int'(LATENCY); k++) begin
      if (i_aclken && free[k]) begin
        vld_d[k] = vld_q[k-1];
        pay_d[k] = pay_q[k-1];
      end
    end
  end

  // Pipeline registers with synchronous reset that discards in-flight beats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      pay_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
    end
  end

  assign o_axis_result_tvalid = vld_q[LATENCY-1];
  assign o_axis_result_tdata  = {4'b0000, pay_q[LATENCY-1][3:0]};
  assign o_axis_result_tuser  = pay_q[LATENCY-1][4];
  assign o_axis_result_tlast  = pay_q[LATENCY-1][5];

endmodule
